// File: rtl/gera_palavra_uns.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gera_palavra_uns                                              |
// | Purpose  : Bit-serial generator of a 16-bit word that holds N ones,      |
// |            packed against bit 0 (lado=0) or bit 15 (lado=1). It is the   |
// |            inverse of the ones-counter and shares its start/pronto       |
// |            handshake and its 2-bit state export.                         |
// | Ports    : clk        - clock, rising edge                                |
// |            reset      - synchronous, active-high reset                    |
// |            start      - run request, level handshake with pronto         |
// |            N[4:0]     - requested number of ones (legal 0..16)            |
// |            lado       - 0: pack from bit 0 up, 1: pack from bit 15 down   |
// |            resultado  - generated word (registered, live while shifting) |
// |            pronto     - registered done flag                             |
// |            erro       - out-of-range count flag                          |
// |            est[1:0]   - current state code                               |
// | Macro    : GERA_UNS_ERRO_EN - when defined, erro reports N>16 for each   |
// |            run; otherwise erro is tied to 0.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gera_palavra_uns (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  N,
  input  logic        lado,
  output logic [15:0] resultado,
  output logic        pronto,
  output logic        erro,
  output logic [1:0]  est
);

  typedef enum logic [1:0] {
    S1    = 2'b00,  // idle
    S2    = 2'b01,  // shifting
    S3    = 2'b10,  // done
    S_BAD = 2'b11   // unreachable; recovers to idle
  } state_t;

  localparam logic [4:0] C_MAX_CNT = 5'd16;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_next;
  logic        r_lado;
  logic        w_lado_next;
  logic [15:0] r_word;
  logic [15:0] w_word_next;
  logic        r_pronto;
  logic        w_pronto_next;
  logic [4:0]  w_cnt_sat;

  // Any count with bit 4 set is >= 16, so it saturates to exactly 16.
  assign w_cnt_sat = N[4] ? C_MAX_CNT : N;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_lado_next   = r_lado;
    w_word_next   = r_word;
    w_pronto_next = 1'b0;
    case (r_state)
      S1: begin
        if (start) begin
          w_lado_next  = lado;
          w_cnt_next   = w_cnt_sat;
          w_word_next  = 16'h0000;
          w_state_next = S2;
        end
      end
      S2: begin
        if (r_cnt == 5'd0) begin
          w_state_next  = S3;
          w_pronto_next = 1'b1;
        end else begin
          w_cnt_next  = r_cnt - 5'd1;
          w_word_next = r_lado ? {1'b1, r_word[15:1]} : {r_word[14:0], 1'b1};
        end
      end
      S3: begin
        if (start) begin
          w_pronto_next = 1'b1;
        end else begin
          w_state_next = S1;
        end
      end
      default: begin
        w_state_next = S1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S1;
      r_cnt    <= 5'd0;
      r_lado   <= 1'b0;
      r_word   <= 16'h0000;
      r_pronto <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_lado   <= w_lado_next;
      r_word   <= w_word_next;
      r_pronto <= w_pronto_next;
    end
  end

`ifdef GERA_UNS_ERRO_EN
  logic r_erro;

  // Flag is refreshed only when a run is accepted, so it describes the
  // most recent request until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_erro <= 1'b0;
    end else if ((r_state == S1) && start) begin
      r_erro <= (N > C_MAX_CNT);
    end
  end

  assign erro = r_erro;
`else
  assign erro = 1'b0;
`endif

  assign resultado = r_word;
  assign pronto    = r_pronto;
  assign est       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gera_palavra_uns.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gera_palavra_uns                                           |
// | Purpose  : Self-checking bench for gera_palavra_uns. Expected words,      |
// |            latencies and error flags are queued when a run is requested  |
// |            and compared when pronto rises.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_gera_palavra_uns;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  N;
  logic        lado;
  logic [15:0] resultado;
  logic        pronto;
  logic        erro;
  logic [1:0]  est;

  typedef struct {
    logic [15:0] word;
    int          lat;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gera_palavra_uns dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .N         (N),
    .lado      (lado),
    .resultado (resultado),
    .pronto    (pronto),
    .erro      (erro),
    .est       (est)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Independent reference for the final word.
  function automatic logic [15:0] model_word(input int n, input logic side);
    int k;
    logic [31:0] lo;
    logic [15:0] all1;
    k    = (n > 16) ? 16 : n;
    lo   = (32'h1 << k) - 32'h1;
    all1 = 16'hFFFF;
    if (side) return ~(all1 >> k);
    return lo[15:0];
  endfunction

  function automatic logic model_err(input int n);
`ifdef GERA_UNS_ERRO_EN
    return (n > 16);
`else
    return 1'b0;
`endif
  endfunction

  // One complete run: request, wait for pronto, check, hold, release.
  // With scramble set, N/lado are altered right after they were sampled.
  task automatic run(input int n, input logic side, input bit scramble, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   seen;
    e.word = model_word(n, side);
    e.lat  = ((n > 16) ? 16 : n) + 1;
    e.err  = model_err(n);
    @(negedge clk);
    N     = n[4:0];
    lado  = side;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);  // E0 samples the request
    if (scramble) begin
      @(negedge clk);
      N    = ~N;
      lado = ~lado;
    end
    cyc  = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (pronto === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk({tag, " latency"}, cyc, got.lat);
      chk({tag, " resultado"}, {16'h0, resultado}, {16'h0, got.word});
      chk({tag, " est done"}, {30'h0, est}, 32'd2);
      chk({tag, " erro"}, {31'h0, erro}, {31'h0, got.err});
      // start still high: S3 must persist
      @(posedge clk);
      @(negedge clk);
      chk({tag, " hold S3"}, {29'h0, pronto, est}, {29'h0, 1'b1, 2'b10});
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " back idle"}, {13'h0, pronto, est, resultado}, {13'h0, 1'b0, 2'b00, got.word});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    N     = 5'd0;
    lado  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset est", {30'h0, est}, 32'd0);
    chk("reset resultado", {16'h0, resultado}, 32'd0);
    chk("reset pronto", {31'h0, pronto}, 32'd0);
    chk("reset erro", {31'h0, erro}, 32'd0);
    reset = 1'b0;

    run(5, 1'b0, 0, "n5_l0");
    run(3, 1'b1, 0, "n3_l1");
    run(0, 1'b0, 0, "n0_l0");
    run(16, 1'b0, 0, "n16_l0");
    run(0, 1'b1, 0, "n0_l1");
    run(16, 1'b1, 0, "n16_l1");
    run(20, 1'b0, 0, "n20_l0");
    run(2, 1'b0, 0, "n2_l0");
    run(31, 1'b1, 0, "n31_l1");
    run(6, 1'b1, 1, "n6_l1_scr");
    run(9, 1'b0, 1, "n9_l0_scr");

    // Reset in the middle of an N=10 run.
    @(negedge clk);
    N     = 5'd10;
    lado  = 1'b0;
    start = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    start = 1'b0;
    N     = 5'd3;
    lado  = 1'b1;
    @(posedge clk);  // E1
    @(posedge clk);  // E2
    @(negedge clk);
    chk("midrun partial", {16'h0, resultado}, 32'h0003);
    chk("midrun est", {30'h0, est}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrun reset", {12'h0, erro, pronto, est, resultado}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("after reset idle", {30'h0, est}, 32'd0);

    run(7, 1'b1, 0, "n7_l1_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
